// File: rtl/pair_uart_tx.sv
// Buffers {lhs,rhs,eol} character pairs in a small FIFO and sends them as UART frames, LSB first.
// Define PAIR_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 instead of 8N1).
module pair_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_lhs,
    input  logic [7:0]              in_rhs,
    input  logic                    in_eol,
    output logic                    tx,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [2:0]              state_dbg
);

    // Handshake: a pair transfers on a rising clk edge where in_valid and in_ready are both high.
    // in_ready is a flop, so it has no combinational dependence on in_valid.
    // Upstream holds the pair stable while in_ready is low.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0]    BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef PAIR_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [16:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_next;
    logic          push, pop, fifo_has;

    logic [2:0] state, state_next;
    logic [7:0] baud, baud_next;
    logic       baud_done;
    logic [2:0] bit_idx, bit_next;
    logic [1:0] sel, sel_next;
    logic       last_byte;
    logic       hold_eol;
    logic [7:0] hold_lhs, hold_rhs;
    logic [7:0] cur_byte;
    logic       tx_next;

    assign push       = in_valid & in_ready;
    assign fifo_has   = (count_q != '0);
    assign count_next = count_q + CW'(push) - CW'(pop);
    assign baud_done  = (baud == BAUD_LAST);
    assign fifo_count = count_q;
    assign state_dbg  = state;

    // Byte selector: 0 lhs, 1 rhs, 2 CR, 3 LF; CR/LF only follow an eol pair.
    assign last_byte = (sel == 2'd3) || ((sel == 2'd1) && !hold_eol);

    always_comb begin
        case (sel)
            2'd0:    cur_byte = hold_lhs;
            2'd1:    cur_byte = hold_rhs;
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_next = state;
        sel_next   = sel;
        bit_next   = bit_idx;
        baud_next  = baud_done ? 8'd0 : baud + 8'd1;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                baud_next = 8'd0;
                if (fifo_has) begin
                    pop        = 1'b1;
                    sel_next   = 2'd0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    bit_next   = 3'd0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef PAIR_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef PAIR_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    if (!last_byte) begin
                        sel_next   = sel + 2'd1;
                        state_next = S_START;
                    end else if (fifo_has) begin
                        pop        = 1'b1;
                        sel_next   = 2'd0;
                        state_next = S_START;
                    end else begin
                        sel_next   = 2'd0;
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        case (state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = cur_byte[bit_idx];
`ifdef PAIR_TX_PARITY_EN
            S_PARITY: tx_next = ^cur_byte;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_eol, in_lhs, in_rhs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
            baud     <= 8'd0;
            bit_idx  <= 3'd0;
            sel      <= 2'd0;
            hold_eol <= 1'b0;
            hold_lhs <= 8'd0;
            hold_rhs <= 8'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {hold_eol, hold_lhs, hold_rhs} <= mem[rd_ptr];
            end
            count_q  <= count_next;
            in_ready <= (count_next != FULL);
            state    <= state_next;
            baud     <= baud_next;
            bit_idx  <= bit_next;
            sel      <= sel_next;
            tx       <= tx_next;
            // Stays high until the final stop bit has actually left the tx flop.
            busy     <= (state != S_IDLE) || (state_next != S_IDLE) || (count_next != '0);
        end
    end

endmodule

// File: tb/tb_pair_uart_tx.sv
// Directed bench for pair_uart_tx: a UART line decoder checks every frame against a queue of expected bytes.
`timescale 1ns/1ps
module tb_pair_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef PAIR_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_lhs = 8'd0;
    logic [7:0] in_rhs = 8'd0;
    logic       in_eol = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       par_q[$];
    longint     start_q[$];
    longint     push_t;
    longint     first_t;
    logic       saw_full = 1'b0;

    int         mon_off = -1;
    int         mon_k;
    logic [7:0] mon_byte;
    logic [7:0] exp_byte;

    pair_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_eol(in_eol),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected completion at %0t", name, $time);
    endtask

    // Line decoder: finds each start bit, samples mid-bit, scores the byte against exp_q.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_off = -1;
        end else begin
            if (mon_off < 0) begin
                if (tx === 1'b0) begin
                    mon_off = 0;
                    start_q.push_back($time);
                end
            end else begin
                mon_off++;
            end
            if (mon_off >= 0) begin
                check("busy_in_frame", busy, 1);
                if (mon_off % CPB == CPB / 2) begin
                    mon_k = mon_off / CPB;
                    if (mon_k == 0) begin
                        check("start_bit", tx, 0);
                    end else if (mon_k <= 8) begin
                        mon_byte[mon_k-1] = tx;
                    end else if (mon_k == NB - 1) begin
                        check("stop_bit", tx, 1);
                        got_q.push_back(mon_byte);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", mon_byte);
                        end else begin
                            exp_byte = exp_q.pop_front();
                            check("frame_byte", mon_byte, exp_byte);
                        end
                        mon_off = -1;
                    end else begin
                        par_q.push_back(tx);
                        check("parity_bit", tx, ^mon_byte);
                    end
                end
            end
        end
    end

    task automatic push_pair(input logic [7:0] l, input logic [7:0] r, input logic e);
        int   guard;
        logic waited;
        guard  = 0;
        waited = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_lhs   = l;
        in_rhs   = r;
        in_eol   = e;
        while (in_ready !== 1'b1 && guard < 2000) begin
            if (!waited) begin
                check("full_count", fifo_count, DEPTH);
                saw_full = 1'b1;
                waited   = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) note_timeout("push_wait");
        @(posedge clk);
        push_t = $time;
        exp_q.push_back(l);
        exp_q.push_back(r);
        if (e) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && mon_off < 0 && busy === 1'b0 && fifo_count == 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) note_timeout(name);
    endtask

    task automatic clear_logs();
        got_q.delete();
        par_q.delete();
        start_q.delete();
    endtask

    task automatic check_tx_quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        // Test 1: reset values, then an idle line.
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_count", fifo_count, 0);
        check_tx_quiet("idle_tx_high_cycles", 100);
        check("idle_no_frames", start_q.size(), 0);

        // Test 2: one plain pair, latency and back-to-back frames.
        clear_logs();
        push_pair(8'h31, 8'h73, 1'b0);
        repeat (2 * FRAME + 2) @(negedge clk);
        check("t2_busy_last_stop", busy, 1);
        @(negedge clk);
        check("t2_busy_after", busy, 0);
        wait_idle("t2_idle");
        check("t2_frames", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t2_byte0", got_q[0], 8'h31);
            check("t2_byte1", got_q[1], 8'h73);
        end
        if (start_q.size() == 2) begin
            check("t2_latency_ns", 32'(start_q[0] - push_t), 25);
            check("t2_gap_ns", 32'(start_q[1] - start_q[0]), 10 * FRAME);
        end else begin
            check("t2_starts", start_q.size(), 2);
        end

        // Test 3: eol pair appends CR LF with no gaps.
        clear_logs();
        push_pair(8'h31, 8'h74, 1'b1);
        repeat (4 * FRAME + 2) @(negedge clk);
        check("t3_busy_last_stop", busy, 1);
        @(negedge clk);
        check("t3_busy_after", busy, 0);
        wait_idle("t3_idle");
        check("t3_frames", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("t3_byte2_cr", got_q[2], 8'h0D);
            check("t3_byte3_lf", got_q[3], 8'h0A);
        end
        if (start_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("t3_gap_ns", 32'(start_q[i] - start_q[i-1]), 10 * FRAME);
        end else begin
            check("t3_starts", start_q.size(), 4);
        end

        // Test 4: eight pairs offered back to back; the FIFO fills and wraps.
        clear_logs();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) push_pair(8'h41 + 8'(i), 8'h61 + 8'(i), 1'b0);
        check("t4_saw_full", saw_full, 1);
        wait_idle("t4_idle");
        check("t4_frames", got_q.size(), 16);
        if (got_q.size() == 16) begin
            check("t4_first", got_q[0], 8'h41);
            check("t4_last", got_q[15], 8'h68);
        end

`ifdef PAIR_TX_PARITY_EN
        // Test 6: even parity bit and 11-bit frames.
        clear_logs();
        push_pair(8'h31, 8'h20, 1'b0);
        wait_idle("t6_idle");
        check("t6_parity_count", par_q.size(), 2);
        if (par_q.size() == 2) begin
            check("t6_parity0", par_q[0], 1);
            check("t6_parity1", par_q[1], 1);
        end
        if (start_q.size() == 2) check("t6_gap_ns", 32'(start_q[1] - start_q[0]), 440);
`endif

        // Test 5: reset in data bit 3 of the first byte with two entries queued.
        clear_logs();
        push_pair(8'h55, 8'h66, 1'b0);
        first_t = push_t;
        push_pair(8'h77, 8'h78, 1'b1);
        push_pair(8'h79, 8'h7A, 1'b0);
        check("t5_push_spacing_ns", 32'(push_t - first_t), 20);
        repeat (18) @(negedge clk);
        check("t5_count_before", fifo_count, 2);
        check("t5_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", in_ready, 1);
        exp_q.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_tx_quiet("t5_quiet_tx", 100);
        check("t5_no_frames", start_q.size(), 0);
        check("t5_count_after", fifo_count, 0);
        check("t5_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
